// File: rtl/tape_ram_if.sv
// Request/response bundle for tape_ram: the requester drives en/op/addr/write,
// the RAM returns read/valid and advertises ready.
interface tape_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  en;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] write;
    logic [DATA_WIDTH-1:0] read;
    logic                  valid;
    logic                  ready;

    modport master (output en, op, addr, write, input read, valid, ready);
    modport slave  (input en, op, addr, write, output read, valid, ready);
endinterface

// File: rtl/tape_ram.sv
// Single-port tape RAM with READ/WRITE and one-bubble INC/DEC read-modify-write.
// Optional TAPE_CLEAR_EN: zero-fill sweep of all cells after every reset.
module tape_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    tape_ram_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

`ifdef TAPE_CLEAR_EN
    typedef enum logic [1:0] {IDLE, RMW, CLEAR} state_t;
    localparam state_t RESET_STATE = CLEAR;
    logic [IDX_W-1:0] clr_cnt_reg;
`else
    typedef enum logic {IDLE, RMW} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                state_reg, state_next;
    logic                  run_reg;
    logic [DATA_WIDTH-1:0] read_reg, read_next;
    logic                  valid_reg, valid_next;
    logic                  from_mem_reg, from_mem_next;
    logic [IDX_W-1:0]      addr_reg;
    logic                  range_reg;
    logic                  dec_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  accept;
    logic                  req_in_range;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] rmw_val;

    assign bus.ready    = run_reg && (state_reg == IDLE);
    assign accept       = bus.en && bus.ready;
    assign req_idx      = bus.addr[IDX_W-1:0];
    assign req_in_range = (32'(bus.addr) < 32'(DEPTH));
    // mem_q was loaded from the captured address at the accepting edge
    assign rmw_val      = dec_reg ? (mem_q - ONE) : (mem_q + ONE);

    // A fresh READ is presented straight from the RAM output register and
    // folded into read_reg on the following edge so the value holds.
    assign bus.read  = from_mem_reg ? mem_q : read_reg;
    assign bus.valid = valid_reg;

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        mem_q <= mem[req_idx];
    end

    always_comb begin
        state_next    = state_reg;
        read_next     = bus.read;
        valid_next    = 1'b0;
        from_mem_next = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = req_idx;
        mem_wdata     = bus.write;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_READ: begin
                            valid_next    = 1'b1;
                            from_mem_next = req_in_range;
                            if (!req_in_range) begin
                                read_next = '0;
                            end
                        end
                        OP_WRITE: mem_we     = req_in_range;
                        default:  state_next = RMW;
                    endcase
                end
            end
            RMW: begin
                state_next = IDLE;
                valid_next = 1'b1;
                read_next  = range_reg ? rmw_val : '0;
                mem_we     = range_reg;
                mem_waddr  = addr_reg;
                mem_wdata  = rmw_val;
            end
`ifdef TAPE_CLEAR_EN
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_reg;
                mem_wdata = '0;
                if (clr_cnt_reg == IDX_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RESET_STATE;
            run_reg      <= 1'b0;
            read_reg     <= '0;
            valid_reg    <= 1'b0;
            from_mem_reg <= 1'b0;
            addr_reg     <= '0;
            range_reg    <= 1'b0;
            dec_reg      <= 1'b0;
`ifdef TAPE_CLEAR_EN
            clr_cnt_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            run_reg      <= 1'b1;
            read_reg     <= read_next;
            valid_reg    <= valid_next;
            from_mem_reg <= from_mem_next;
            if (accept) begin
                addr_reg  <= req_idx;
                range_reg <= req_in_range;
                dec_reg   <= bus.op[0];
            end
`ifdef TAPE_CLEAR_EN
            if (state_reg == CLEAR) begin
                clr_cnt_reg <= clr_cnt_reg + IDX_W'(1);
            end
`endif
        end
    end
endmodule
